gpu_load_store_unit: RTL and testbench
======================================

Name: gpu_load_store_unit

Overview:
Executes RV32I/F load and store instructions (LB/LH/LW/LBU/LHU, SB/SH/SW, FLW/FSW) for the shader core's multicycle sequencer. It is started by the sequencer's load/store step once the decoder and register file have settled. It drives the data BlockRam port and returns a sign/zero-extended load value with a one-cycle done pulse. Sub-word stores are performed as read-modify-write, because the data RAM has no byte enables.

Parameters:
ADDR_WIDTH, 16, byte-address width presented to the data RAM; word index is mem_address[ADDR_WIDTH-1:2].
READ_LATENCY, 1, number of cycles from mem_address valid to mem_read_data valid (BlockRam registered read = 1).

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
is_load  input  1  request is a load (integer or FLW)
is_store  input  1  request is a store (integer or FSW)
funct3  input  3  width/sign selector from decoder
base  input  32  rs1 value
offset  input  32  sign-extended immediate (imm_alu_load or imm_store)
store_data  input  32  rs2 value (integer or float register)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
fault  output  1  valid with done; misaligned address or illegal funct3
load_data  output  32  extended load result; valid with done, held until next done
mem_address  output  ADDR_WIDTH  data RAM byte address (registered)
mem_write  output  1  data RAM write enable (registered)
mem_write_data  output  32  data RAM write word (registered)
mem_read_data  input  32  data RAM read word

Behaviour:
- Reset: state IDLE; busy=0, done=0, fault=0, mem_write=0, load_data=0, mem_address=0, mem_write_data=0. Reset mid-operation aborts at once: no further mem_write, and no done is issued.
- Effective address ea = base + offset, mod 2^32. Bits above ADDR_WIDTH are ignored. Little-endian byte lanes: ea[1:0]=0 selects bits [7:0].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Alignment: halfword needs ea[0]=0; word needs ea[1:0]=0.
- States: IDLE, READ_WAIT, WRITE, DONE.
- IDLE, start=0, or start=1 with is_load=is_store=0: stay IDLE, nothing happens.
- IDLE, start=1 and any of is_load&is_store, illegal funct3, or misaligned:
  - Go to DONE with fault=1.
  - No memory access; mem_address is not updated.
- IDLE, start=1 with a load or a sub-word store: latch funct3, ea[1:0], store_data; register mem_address=ea; go to READ_WAIT.
- IDLE, start=1 with SW: register mem_address=ea, mem_write_data=store_data, mem_write=1; go to WRITE.
- READ_WAIT counts READ_LATENCY cycles after the address becomes valid, then samples mem_read_data.
  - Load: extract the byte/halfword/word at the latched lane, sign- or zero-extend into load_data, go to DONE.
  - Sub-word store: merge the latched store bytes into the read word, register mem_write_data, assert mem_write=1, go to WRITE.
- WRITE: mem_write is high for exactly this one cycle; deassert, go to DONE.
- DONE: done=1 (fault as determined) for exactly one cycle; return to IDLE.
- Latency with READ_LATENCY=1, counting from the start-sampling edge E0 to the edge after which done is high:
  - fault: E0 (1 edge)
  - SW: E1 (2 edges)
  - loads: READ_LATENCY+1 edges
  - SB/SH: READ_LATENCY+2 edges
- start while busy is ignored, not queued. Inputs other than start need only be valid in the start cycle.

Decomposition:
- Package gpu_lsu_pkg:
  - funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - state encoding (2-bit)
  - alignment-check function
- One combinational sub-module, lsu_lane_align:
  - inputs: lane, funct3, read word, store data
  - outputs: extended load value, merged store word
- lsu_lane_align is unit-testable on its own.

Test Plan:
- RAM[0x100]=0x8899AABB; LB base=0x100 offset=1 -> done after 2 edges, load_data=0xFFFFFFAA, fault=0, mem_write never high.
- Same RAM; LBU base=0x104 offset=0xFFFFFFFF (ea=0x103) -> load_data=0x00000088. LHU offset 2 -> 0x00008899. LH offset 2 -> 0xFFFF8899.
- SB base=0x100 offset=2 data=0x12345611 -> one mem_write pulse, RAM[0x100]=0x8811AABB, done after 3 edges.
- SW base=0x200 data=0xDEADBEEF -> mem_write high exactly 1 cycle with address 0x200, done after 2 edges; LW 0x200 returns 0xDEADBEEF.
- LW ea=0x102, SH ea=0x101, and load funct3=011 -> each gives done=1, fault=1 after 1 edge, no mem_write, RAM unchanged.
- start re-pulsed while busy is ignored. reset_n=0 during an SB's READ_WAIT -> mem_write never asserts, RAM unchanged, busy=0 the next cycle.

Source files
------------

// File: rtl/gpu_lsu_pkg.sv
// rtl/gpu_lsu_pkg.sv - shared constants and helpers for the shader load/store unit
package gpu_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_WAIT = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Access width lives in funct3[1:0]; the unsigned flag in funct3[2] does not affect alignment.
    function automatic logic lsu_aligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return !lane[0];
            2'b10:   return lane == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic is_load, input logic [2:0] funct3);
        if (is_load)
            return funct3 == LSU_B || funct3 == LSU_H || funct3 == LSU_W ||
                   funct3 == LSU_BU || funct3 == LSU_HU;
        else
            return funct3 == LSU_B || funct3 == LSU_H || funct3 == LSU_W;
    endfunction

endpackage

// File: rtl/gpu_load_store_unit_if.sv
// rtl/gpu_load_store_unit_if.sv - data BlockRam port between the load/store unit and the RAM
interface gpu_load_store_unit_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_write;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;

    modport master (
        output mem_address,
        output mem_write,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extraction/extension for loads and merge for sub-word stores
module lsu_lane_align
    import gpu_lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [4:0]  shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lane_mask;

    assign shift = {lane, 3'b000};

    always_comb begin
        byte_sel = 8'(read_word >> shift);
        half_sel = 16'(read_word >> {lane[1], 4'b0000});
        case (funct3)
            LSU_B:   load_value = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   load_value = {{16{half_sel[15]}}, half_sel};
            LSU_BU:  load_value = {24'h000000, byte_sel};
            LSU_HU:  load_value = {16'h0000, half_sel};
            default: load_value = read_word;
        endcase
    end

    // Halfword stores are aligned, so lane*8 equals lane[1]*16 and one shift serves both widths.
    always_comb begin
        case (funct3[1:0])
            2'b00:   lane_mask = 32'h0000_00FF << shift;
            2'b01:   lane_mask = 32'h0000_FFFF << shift;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        store_word = (read_word & ~lane_mask) | ((store_data << shift) & lane_mask);
    end

endmodule

// File: rtl/gpu_load_store_unit.sv
// rtl/gpu_load_store_unit.sv - multicycle RV32I/F load/store engine driving the data BlockRam
module gpu_load_store_unit
    import gpu_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    gpu_load_store_unit_if.master mem
);

    localparam logic [7:0] LAST_WAIT = 8'(READ_LATENCY - 1);

    logic [1:0]  state;
    logic [7:0]  wait_count;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] store_data_q;
    logic        is_store_q;
    logic        fault_q;

    logic [31:0] ea;
    logic        ea_unused;
    logic        request;
    logic        bad_request;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign ea        = base + offset;
    assign ea_unused = ^ea[31:ADDR_WIDTH];
    assign request   = start && (is_load || is_store);
    assign bad_request = (is_load && is_store) || !lsu_legal(is_load, funct3) ||
                         !lsu_aligned(funct3, ea[1:0]);

    assign busy  = state != ST_IDLE;
    assign done  = state == ST_DONE;
    assign fault = done && fault_q;

    lsu_lane_align u_lane_align (
        .lane       (lane_q),
        .funct3     (funct3_q),
        .read_word  (mem.mem_read_data),
        .store_data (store_data_q),
        .load_value (load_value),
        .store_word (store_word)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            wait_count         <= 8'd0;
            funct3_q           <= 3'b000;
            lane_q             <= 2'b00;
            store_data_q       <= 32'h0;
            is_store_q         <= 1'b0;
            fault_q            <= 1'b0;
            load_data          <= 32'h0;
            mem.mem_address    <= '0;
            mem.mem_write      <= 1'b0;
            mem.mem_write_data <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        if (bad_request) begin
                            fault_q <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            fault_q         <= 1'b0;
                            mem.mem_address <= ea[ADDR_WIDTH-1:0];
                            funct3_q        <= funct3;
                            lane_q          <= ea[1:0];
                            store_data_q    <= store_data;
                            is_store_q      <= is_store;
                            if (is_store && funct3 == LSU_W) begin
                                // Full words need no read; write straight away.
                                mem.mem_write_data <= store_data;
                                mem.mem_write      <= 1'b1;
                                state              <= ST_WRITE;
                            end else begin
                                wait_count <= 8'd0;
                                state      <= ST_READ_WAIT;
                            end
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (wait_count == LAST_WAIT) begin
                        if (is_store_q) begin
                            mem.mem_write_data <= store_word;
                            mem.mem_write      <= 1'b1;
                            state              <= ST_WRITE;
                        end else begin
                            load_data <= load_value;
                            state     <= ST_DONE;
                        end
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                ST_WRITE: begin
                    mem.mem_write <= 1'b0;
                    state         <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_load_store_unit.sv
// tb/tb_gpu_load_store_unit.sv - directed vector bench for gpu_load_store_unit against a small RAM model
module tb_gpu_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] base = 32'h0;
    logic [31:0] offset = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, fault;
    logic [31:0] load_data;

    gpu_load_store_unit_if #(.ADDR_WIDTH(16)) mem_bus ();

    gpu_load_store_unit #(.ADDR_WIDTH(16), .READ_LATENCY(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem        (mem_bus)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [0:1023];
    int          write_cycles = 0;
    int          done_count = 0;
    logic [15:0] last_waddr = 16'h0;

    assign mem_bus.mem_read_data = ram[mem_bus.mem_address[11:2]];

    always @(posedge clock) begin
        if (mem_bus.mem_write) begin
            ram[mem_bus.mem_address[11:2]] <= mem_bus.mem_write_data;
            write_cycles = write_cycles + 1;
            last_waddr   = mem_bus.mem_address;
        end
    end

    always @(negedge clock) if (done) done_count = done_count + 1;

    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] sd;
        int          edges;
        logic        flt;
        logic        chk_ld;
        logic [31:0] ld_val;
        int          writes;
        logic [15:0] waddr;
        logic [15:0] chk_addr;
        logic [31:0] chk_word;
    } vec_t;

    vec_t vecs[$];

    // Issue one request once the unit is idle; returns edges from E0 until done is seen.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd,
                         output int edges, output logic flt);
        int guard;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        is_load = ld; is_store = st; funct3 = f3; base = b; offset = o; store_data = sd;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        is_load = 1'b0; is_store = 1'b0; base = 32'hFFFF_FFFF; store_data = 32'h0BAD_0BAD;
        edges = 1;
        while (!done && edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
        end
        flt = fault;
    endtask

    initial begin
        int          edges;
        logic        flt;
        int          w0;
        int          d0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[12'h100 >> 2] = 32'h8899_AABB;

        //          ld    st    f3      base          off           sd            ed flt chk ld_val        wr waddr     chk_addr  chk_word
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h100, 32'h1,        32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFAA, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h104, 32'hFFFFFFFF, 32'h0,        2, 1'b0, 1'b1, 32'h00000088, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h100, 32'h2,        32'h0,        2, 1'b0, 1'b1, 32'h00008899, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h100, 32'h2,        32'h0,        2, 1'b0, 1'b1, 32'hFFFF8899, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h100, 32'h0,        32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFBB, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h0,        2, 1'b0, 1'b1, 32'hFFFFAABB, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        2, 1'b0, 1'b1, 32'h8899AABB, 0, 16'h0,   16'h100, 32'h8899AABB});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h100, 32'h2,        32'h12345611, 3, 1'b0, 1'b0, 32'h0,        1, 16'h102, 16'h100, 32'h8811AABB});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h200, 32'h0,        32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0,        1, 16'h200, 16'h200, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        2, 1'b0, 1'b1, 32'hDEADBEEF, 0, 16'h0,   16'h200, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h1FE, 32'h4,        32'h7777CAFE, 3, 1'b0, 1'b0, 32'h0,        1, 16'h202, 16'h200, 32'hCAFEBEEF});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h200, 32'h2,        32'h0,        2, 1'b0, 1'b1, 32'hFFFFCAFE, 0, 16'h0,   16'h200, 32'hCAFEBEEF});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h203, 32'h0,        32'h000000AA, 3, 1'b0, 1'b0, 32'h0,        1, 16'h203, 16'h200, 32'hAAFEBEEF});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h0,        2, 1'b0, 1'b1, 32'h000000AA, 0, 16'h0,   16'h200, 32'hAAFEBEEF});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h100, 32'h2,        32'h0,        1, 1'b1, 1'b0, 32'h0,        0, 16'h0,   16'h100, 32'h8811AABB});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h100, 32'h1,        32'h5555,     1, 1'b1, 1'b0, 32'h0,        0, 16'h0,   16'h100, 32'h8811AABB});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1'b1, 1'b0, 32'h0,        0, 16'h0,   16'h100, 32'h8811AABB});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 1'b1, 1'b0, 32'h0,        0, 16'h0,   16'h100, 32'h8811AABB});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        1, 1'b1, 1'b0, 32'h0,        0, 16'h0,   16'h100, 32'h8811AABB});

        repeat (3) @(posedge clock);
        #1;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset fault", {31'h0, fault}, 32'h0);
        check("reset mem_write", {31'h0, mem_bus.mem_write}, 32'h0);
        check("reset load_data", load_data, 32'h0);
        check("reset mem_address", {16'h0, mem_bus.mem_address}, 32'h0);
        check("reset mem_write_data", mem_bus.mem_write_data, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            w0 = write_cycles;
            issue(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].base, vecs[i].off, vecs[i].sd, edges, flt);
            check($sformatf("v%0d edges", i), 32'(edges), 32'(vecs[i].edges));
            check($sformatf("v%0d fault", i), {31'h0, flt}, {31'h0, vecs[i].flt});
            if (vecs[i].chk_ld)
                check($sformatf("v%0d load_data", i), load_data, vecs[i].ld_val);
            check($sformatf("v%0d write cycles", i), 32'(write_cycles - w0), 32'(vecs[i].writes));
            if (vecs[i].writes > 0)
                check($sformatf("v%0d write address", i), {16'h0, last_waddr}, {16'h0, vecs[i].waddr});
            @(negedge clock);
            check($sformatf("v%0d ram word", i), ram[vecs[i].chk_addr[11:2]], vecs[i].chk_word);
        end

        // start held high while busy, with a conflicting store request presented
        @(negedge clock);
        @(negedge clock);
        w0 = write_cycles;
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h100; offset = 32'h0;
        start = 1'b1;
        @(posedge clock);
        #1;
        is_load = 1'b0; is_store = 1'b1; base = 32'h300; store_data = 32'h1234_5678;
        edges = 1;
        while (!done && edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
        end
        check("busy restart edges", 32'(edges), 32'd2);
        check("busy restart load_data", load_data, 32'h8811AABB);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("busy restart idle", {31'h0, busy}, 32'h0);
        check("busy restart writes", 32'(write_cycles - w0), 32'd0);
        check("busy restart ram", ram[12'h300 >> 2], 32'h0);

        // reset during the read phase of a byte store
        @(negedge clock);
        w0 = write_cycles;
        d0 = done_count;
        is_load = 1'b0; is_store = 1'b1; funct3 = 3'b000; base = 32'h200; offset = 32'h1;
        store_data = 32'h0000_0055;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("abort in read wait", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort mem_write", {31'h0, mem_bus.mem_write}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("abort writes", 32'(write_cycles - w0), 32'd0);
        check("abort done", 32'(done_count - d0), 32'd0);
        check("abort ram", ram[12'h200 >> 2], 32'hAAFEBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
